instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 20, instruction word width.
REQ-002 SHALL have parameter ADDR_BITS, default 5, program-counter width (32 instruction addresses).
REQ-003 SHALL have parameter PROG_LAST, default 31, last valid program address; the PC wraps to 0 after it.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, a one-cycle pulse that begins execution from PC 0.
REQ-007 SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-008 SHALL have port imem_addr, output, ADDR_BITS, read address, equal to the current PC.
REQ-009 SHALL have port imem_ack, input, 1, read data valid, accepted on any cycle after imem_req.
REQ-010 SHALL have port imem_rdata, input, INSTR_WIDTH, read data.
REQ-011 SHALL have port instr, output, INSTR_WIDTH, the instruction presented to the control unit.
REQ-012 SHALL have port instr_valid, output, 1, high while instr is being held for execution.
REQ-013 SHALL have port pc, output, ADDR_BITS, the current program counter.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE and HALT.
REQ-015 SHALL have port halted, output, 1, high in HALT.
REQ-016 SHALL have port instr_count, output, 16, the number of retired instructions; it wraps modulo 2^16.

Function
REQ-017 SHALL implement the states IDLE, FETCH, HOLD and HALT.
REQ-018 SHALL move from IDLE to FETCH on start, with pc=0 and instr_count=0.
REQ-019 SHALL, in FETCH, drive imem_req=1, keep it high until imem_ack, and hold instr at its previous value with instr_valid=0.
REQ-020 SHALL, on imem_ack in FETCH, latch imem_rdata into instr on that edge.
REQ-021 SHALL go from FETCH to HALT when imem_rdata[19:18]=00, forcing instr to 0 and leaving pc unchanged.
REQ-022 SHALL otherwise go from FETCH to HOLD and load the hold counter with the class length: 01 std_op = 3, 10 loadR = 4, 11 storeR = 3.
REQ-023 SHALL, in HOLD, drive instr_valid=1, keep instr stable, and decrement the counter each cycle.
REQ-024 SHALL, on the last HOLD cycle, increment instr_count and advance pc (PROG_LAST wraps to 0), then enter FETCH.
REQ-025 SHALL drive imem_req=0 in every state except FETCH.
REQ-026 SHALL ignore start unless in IDLE or HALT; start in HALT restarts the program from pc=0.
REQ-027 SHALL treat imem_ack outside FETCH as a no-op.
REQ-028 SHALL recover from any illegal state encoding by returning to IDLE on the next edge.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, set state=IDLE, pc=0, instr=0, instr_valid=0, imem_req=0, imem_addr=0, busy=0, halted=0, instr_count=0 and the hold counter to 0.
REQ-030 SHALL let reset asserted mid-FETCH or mid-HOLD abort the instruction with no retire and no pc change, and SHALL give reset priority over start.

Configuration
REQ-031 SHALL, when macro INSTR_SEQUENCER_SINGLE_STEP_EN is defined, add input step (1 bit) and a STEP_WAIT state entered after every retire; the block stays there with instr_valid=0 and instr held until a step pulse, then enters FETCH.
REQ-032 SHALL, when INSTR_SEQUENCER_SINGLE_STEP_EN is undefined, have no step port and no STEP_WAIT state, with retire going directly to FETCH.

Verification
REQ-033 SHALL cover: rst then start, imem returns 0x5_1234 (class 01) with one-cycle ack -> instr=0x51234, instr_valid high for exactly 3 cycles, then pc=1, instr_count=1.
REQ-034 SHALL cover: program of loadR (0x8_0010) then storeR (0xC_0020) -> hold lengths of 4 then 3 cycles, and instr_count=2.
REQ-035 SHALL cover: imem_ack delayed 5 cycles -> imem_req held high for 5 cycles, instr_valid=0 throughout, and instr unchanged.
REQ-036 SHALL cover: word 0x0_0000 at pc=2 -> HALT with halted=1, busy=0, pc=2, instr=0; then start -> pc=0 and refetch.
REQ-037 SHALL cover: 32 class-01 words with no halt -> after the instruction at pc=31 retires, pc wraps to 0 and instr_count=32.
REQ-038 SHALL cover: rst pulsed in the 2nd HOLD cycle -> next cycle IDLE, pc=0, instr=0, instr_count=0; start during rst ignored.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/hold instruction sequencer driving a control unit from a small instruction memory.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             one-cycle pulse; begins (or restarts from HALT) execution at pc 0
//   step              single-step advance pulse (only with INSTR_SEQUENCER_SINGLE_STEP_EN)
//   imem_req/addr     instruction read request and address (address is the pc)
//   imem_ack/rdata    read data valid and read data
//   instr/instr_valid instruction held for execution and its valid flag
//   pc, busy, halted  program counter and status
//   instr_count       retired instruction count, wraps modulo 2^16
// Optional feature: define INSTR_SEQUENCER_SINGLE_STEP_EN to add the step input and STEP_WAIT state.
module instr_sequencer #(
    parameter int INSTR_WIDTH = 20,
    parameter int ADDR_BITS   = 5,
    parameter int PROG_LAST   = 31
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    input  logic                   step,
`endif
    output logic                   imem_req,
    output logic [ADDR_BITS-1:0]   imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    output logic [ADDR_BITS-1:0]   pc,
    output logic                   busy,
    output logic                   halted,
    output logic [15:0]            instr_count
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        HOLD      = 3'd2,
        HALT      = 3'd3
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
        ,STEP_WAIT = 3'd4
`endif
    } state_t;

    state_t                 state, state_next;
    logic [ADDR_BITS-1:0]   pc_next;
    logic [INSTR_WIDTH-1:0] instr_next;
    logic [2:0]             cnt, cnt_next;
    logic [15:0]            count_next;
    logic [1:0]             cls;

    // Instruction class lives in the top two bits of the word.
    assign cls       = imem_rdata[INSTR_WIDTH-1 -: 2];
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            instr       <= '0;
            cnt         <= '0;
            instr_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr       <= instr_next;
            cnt         <= cnt_next;
            instr_count <= count_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        instr_next  = instr;
        cnt_next    = cnt;
        count_next  = instr_count;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        busy        = 1'b1;
        halted      = 1'b0;
        case (state)
            IDLE, HALT: begin
                busy   = 1'b0;
                halted = (state == HALT);
                if (start) begin
                    state_next = FETCH;
                    pc_next    = '0;
                    count_next = '0;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = (cls == 2'b00) ? HALT : HOLD;
                    instr_next = (cls == 2'b00) ? '0 : imem_rdata;
                    cnt_next   = (cls == 2'b10) ? 3'd4 : 3'd3;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                cnt_next    = cnt - 3'd1;
                // cnt counts remaining hold cycles including this one; 1 means retire now.
                if (cnt <= 3'd1) begin
                    cnt_next   = '0;
                    count_next = instr_count + 16'd1;
                    pc_next    = (pc == ADDR_BITS'(PROG_LAST)) ? '0 : pc + 1'b1;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
                    state_next = STEP_WAIT;
`else
                    state_next = FETCH;
`endif
                end
            end
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
            STEP_WAIT: begin
                if (step) state_next = FETCH;
            end
`endif
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench for instr_sequencer with a delay-programmable instruction memory responder.
module tb_instr_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        imem_ack = 1'b0;
    logic [19:0] imem_rdata = '0;
    logic        imem_req;
    logic [4:0]  imem_addr;
    logic [19:0] instr;
    logic        instr_valid;
    logic [4:0]  pc;
    logic        busy;
    logic        halted;
    logic [15:0] instr_count;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr(instr),
        .instr_valid(instr_valid),
        .pc(pc),
        .busy(busy),
        .halted(halted),
        .instr_count(instr_count)
    );

    typedef struct {
        logic [19:0] word;
        logic [4:0]  addr;
        int          len;
    } exp_t;

    exp_t        sb[$];
    logic [19:0] mem[32];
    int          ack_delay = 0;
    int          compared = 0;
    int          mismatched = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: acks ack_delay cycles after it first sees a request and
    // pushes the expected held instruction for every non-halt word it returns.
    initial begin
        int wcnt;
        logic [19:0] w;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (rst || !imem_req) begin
                wcnt = 0;
            end else if (wcnt == ack_delay) begin
                w = mem[imem_addr];
                imem_ack = 1'b1;
                imem_rdata = w;
                wcnt = 0;
                if (w[19:18] != 2'b00)
                    sb.push_back('{w, imem_addr, (w[19:18] == 2'b10) ? 4 : 3});
            end else begin
                wcnt++;
            end
        end
    end

    // Output monitor: pops an expectation on each instr_valid rise and checks
    // instruction, pc, stability, hold length and fetch-phase behaviour.
    initial begin
        exp_t cur;
        int vlen, rlen;
        logic pv, pr;
        logic [19:0] fetch_instr;
        vlen = 0; rlen = 0; pv = 0; pr = 0; fetch_instr = '0;
        cur = '{20'h0, 5'h0, 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                pv = 0;
                pr = 0;
            end else begin
                if (imem_req) begin
                    if (!pr) begin
                        rlen = 0;
                        fetch_instr = instr;
                    end
                    rlen++;
                    check("fetch_valid_low", instr_valid, 0);
                    check("fetch_instr_held", instr, fetch_instr);
                end else if (pr) begin
                    check("req_cycles", rlen, ack_delay + 1);
                end
                if (instr_valid && !pv) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        cur = sb.pop_front();
                        check("instr", instr, cur.word);
                        check("hold_pc", pc, cur.addr);
                    end
                    vlen = 0;
                end
                if (instr_valid) begin
                    vlen++;
                    check("hold_instr_stable", instr, cur.word);
                end else if (pv) begin
                    check("hold_len", vlen, cur.len);
                end
                pv = instr_valid;
                pr = imem_req;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_halted(input int limit);
        int n;
        n = 0;
        while (!halted && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!halted) check("timeout_halt", 0, 1);
    endtask

    task automatic wait_count(input int target, input int limit);
        int n;
        n = 0;
        while (instr_count != 16'(target) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (instr_count != 16'(target)) check("timeout_count", instr_count, target);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = '0;
    endtask

    initial begin
        int n;
        clear_mem();
        // Reset with start held high: start must be ignored.
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 0);
        check("rst_instr", instr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_count", instr_count, 0);
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_rst", busy, 0);

        // Single std_op then halt at pc 1.
        mem[0] = 20'h51234;
        pulse_start();
        check("start_req", imem_req, 1);
        wait_count(1, 50);
        check("t1_pc", pc, 1);
        check("t1_count", instr_count, 1);
        wait_halted(50);
        check("t1_halt_pc", pc, 1);

        // loadR, storeR, halt at pc 2, then restart from HALT.
        clear_mem();
        mem[0] = 20'h80010;
        mem[1] = 20'hC0020;
        do_reset();
        pulse_start();
        wait_halted(100);
        check("halt_halted", halted, 1);
        check("halt_busy", busy, 0);
        check("halt_pc", pc, 2);
        check("halt_instr", instr, 0);
        check("halt_count", instr_count, 2);
        check("halt_req", imem_req, 0);
        pulse_start();
        check("restart_pc", pc, 0);
        check("restart_req", imem_req, 1);
        check("restart_busy", busy, 1);
        check("restart_halted", halted, 0);
        wait_halted(100);

        // Delayed acknowledge on every fetch.
        clear_mem();
        mem[0] = 20'h51111;
        mem[1] = 20'h92222;
        ack_delay = 4;
        do_reset();
        pulse_start();
        wait_halted(200);
        check("delay_count", instr_count, 2);
        check("delay_pc", pc, 2);
        ack_delay = 0;

        // 32 std_op words: pc wraps after address 31.
        for (int i = 0; i < 32; i++) mem[i] = 20'h40000 | 20'(i);
        do_reset();
        pulse_start();
        wait_count(32, 400);
        check("wrap_pc", pc, 0);
        check("wrap_count", instr_count, 32);

        // Reset in the second HOLD cycle, with start asserted alongside.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 20);
        check("hold_seen", instr_valid, 1);
        @(posedge clk);
        #1;
        check("second_hold", instr_valid, 1);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_pc", pc, 0);
        check("abort_instr", instr, 0);
        check("abort_count", instr_count, 0);
        check("abort_valid", instr_valid, 0);
        check("abort_req", imem_req, 0);
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("start_in_rst_ignored", busy, 0);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
